axi_write_xbar: RTL and testbench

//  2-master x 2-slave AXI write-channel interconnect (AW/W/B); write-side companion of the read interconnect.

---
 rtl/axi_pkg.sv | 17 +
 rtl/axi_rr_arb2.sv | 9 +
 rtl/axi_write_xbar.sv | 210 +++++++++++++++++++++
 tb/tb_axi_write_xbar.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI write-interconnect definitions: bus widths, response codes,
// slave address bases and the write-path state encoding.
package axi_pkg;
  localparam int ID_BITS   = 4;
  localparam int SID_BITS  = ID_BITS + 4;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;
  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int LEN_BITS  = 4;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [15:0] S0_BASE     = 16'h0000;
  localparam logic [15:0] S1_BASE     = 16'h0001;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wr_state_t;
endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes
// to whichever master was not granted last.
module axi_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);
  assign grant = (&req) ? ~last_grant : req[1];
endmodule

// File: rtl/axi_write_xbar.sv
// 2x2 AXI write interconnect (AW/W/B), one transaction in flight.
// Define AXI_WR_DECERR_EN to answer unmapped addresses with an internal DECERR slave.
module axi_write_xbar
  import axi_pkg::*;
(
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [ID_BITS-1:0]   AWID_M0, AWID_M1,
  input  logic [ADDR_BITS-1:0] AWADDR_M0, AWADDR_M1,
  input  logic [LEN_BITS-1:0]  AWLEN_M0, AWLEN_M1,
  input  logic [2:0]           AWSIZE_M0, AWSIZE_M1,
  input  logic [1:0]           AWBURST_M0, AWBURST_M1,
  input  logic                 AWVALID_M0, AWVALID_M1,
  output logic                 AWREADY_M0, AWREADY_M1,
  input  logic [DATA_BITS-1:0] WDATA_M0, WDATA_M1,
  input  logic [STRB_BITS-1:0] WSTRB_M0, WSTRB_M1,
  input  logic                 WLAST_M0, WLAST_M1,
  input  logic                 WVALID_M0, WVALID_M1,
  output logic                 WREADY_M0, WREADY_M1,
  output logic [ID_BITS-1:0]   BID_M0, BID_M1,
  output logic [1:0]           BRESP_M0, BRESP_M1,
  output logic                 BVALID_M0, BVALID_M1,
  input  logic                 BREADY_M0, BREADY_M1,
  output logic [SID_BITS-1:0]  AWID_S0, AWID_S1,
  output logic [ADDR_BITS-1:0] AWADDR_S0, AWADDR_S1,
  output logic [LEN_BITS-1:0]  AWLEN_S0, AWLEN_S1,
  output logic [2:0]           AWSIZE_S0, AWSIZE_S1,
  output logic [1:0]           AWBURST_S0, AWBURST_S1,
  output logic                 AWVALID_S0, AWVALID_S1,
  input  logic                 AWREADY_S0, AWREADY_S1,
  output logic [DATA_BITS-1:0] WDATA_S0, WDATA_S1,
  output logic [STRB_BITS-1:0] WSTRB_S0, WSTRB_S1,
  output logic                 WLAST_S0, WLAST_S1,
  output logic                 WVALID_S0, WVALID_S1,
  input  logic                 WREADY_S0, WREADY_S1,
  input  logic [SID_BITS-1:0]  BID_S0, BID_S1,
  input  logic [1:0]           BRESP_S0, BRESP_S1,
  input  logic                 BVALID_S0, BVALID_S1,
  output logic                 BREADY_S0, BREADY_S1
);
  wire [1:0][ID_BITS-1:0]   m_awid    = {AWID_M1, AWID_M0};
  wire [1:0][ADDR_BITS-1:0] m_awaddr  = {AWADDR_M1, AWADDR_M0};
  wire [1:0][LEN_BITS-1:0]  m_awlen   = {AWLEN_M1, AWLEN_M0};
  wire [1:0][2:0]           m_awsize  = {AWSIZE_M1, AWSIZE_M0};
  wire [1:0][1:0]           m_awburst = {AWBURST_M1, AWBURST_M0};
  wire [1:0]                m_awvalid = {AWVALID_M1, AWVALID_M0};
  wire [1:0][DATA_BITS-1:0] m_wdata   = {WDATA_M1, WDATA_M0};
  wire [1:0][STRB_BITS-1:0] m_wstrb   = {WSTRB_M1, WSTRB_M0};
  wire [1:0]                m_wvalid  = {WVALID_M1, WVALID_M0};
  wire [1:0]                m_bready  = {BREADY_M1, BREADY_M0};
  wire [1:0]                s_awready = {AWREADY_S1, AWREADY_S0};
  wire [1:0]                s_wready  = {WREADY_S1, WREADY_S0};
  wire [1:0][SID_BITS-1:0]  s_bid     = {BID_S1, BID_S0};
  wire [1:0][1:0]           s_bresp   = {BRESP_S1, BRESP_S0};
  wire [1:0]                s_bvalid  = {BVALID_S1, BVALID_S0};

  logic [1:0]                m_awready, m_wready, m_bvalid;
  logic [1:0][ID_BITS-1:0]   m_bid;
  logic [1:0][1:0]           m_bresp, s_awburst;
  logic [1:0][SID_BITS-1:0]  s_awid;
  logic [1:0][ADDR_BITS-1:0] s_awaddr;
  logic [1:0][LEN_BITS-1:0]  s_awlen;
  logic [1:0][2:0]           s_awsize;
  logic [1:0]                s_awvalid, s_wlast, s_wvalid, s_bready;
  logic [1:0][DATA_BITS-1:0] s_wdata;
  logic [1:0][STRB_BITS-1:0] s_wstrb;

  wr_state_t           state;
  logic                grant, last_grant, arb_grant;
  logic [1:0]          tsel;  // one-hot target slave; 2'b00 only for the internal DECERR slave
  logic [LEN_BITS-1:0] len_q, beat_cnt;
`ifdef AXI_WR_DECERR_EN
  logic [ID_BITS-1:0]  id_q;
`endif

  axi_rr_arb2 u_arb (.req(m_awvalid), .last_grant(last_grant), .grant(arb_grant));

  function automatic logic [1:0] decode(input logic [15:0] hi);
    if (hi == S0_BASE) return 2'b01;
    if (hi == S1_BASE) return 2'b10;
`ifdef AXI_WR_DECERR_EN
    return 2'b00;
`else
    return 2'b10;
`endif
  endfunction

  logic                sel_awready, sel_wready, sel_bvalid;
  logic [SID_BITS-1:0] sel_bid;
  logic [1:0]          sel_bresp;
  always_comb begin
    sel_awready = 1'b0;
    sel_wready  = 1'b0;
    sel_bvalid  = 1'b0;
    sel_bid     = '0;
    sel_bresp   = RESP_OKAY;
    for (int i = 0; i < 2; i++)
      if (tsel[i]) begin
        sel_awready = s_awready[i];
        sel_wready  = s_wready[i];
        sel_bvalid  = s_bvalid[i];
        sel_bid     = s_bid[i];
        sel_bresp   = s_bresp[i];
      end
`ifdef AXI_WR_DECERR_EN
    if (tsel == 2'b00) begin
      sel_awready = 1'b1;
      sel_wready  = 1'b1;
      sel_bvalid  = 1'b1;
      sel_bid     = {4'h0, id_q};
      sel_bresp   = RESP_DECERR;
    end
`endif
  end

  // Everything routes off registered grant/tsel, so IDLE drives all zeros.
  always_comb begin
    m_awready = '0; m_wready = '0; m_bvalid = '0; m_bid = '0; m_bresp = '0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
    case (state)
      ADDR: begin
        m_awready[grant] = sel_awready;
        for (int i = 0; i < 2; i++)
          if (tsel[i]) begin
            s_awvalid[i] = m_awvalid[grant];
            s_awid[i]    = {(grant ? 4'h2 : 4'h1), m_awid[grant]};
            s_awaddr[i]  = m_awaddr[grant];
            s_awlen[i]   = m_awlen[grant];
            s_awsize[i]  = m_awsize[grant];
            s_awburst[i] = m_awburst[grant];
          end
      end
      DATA: begin
        m_wready[grant] = sel_wready;
        for (int i = 0; i < 2; i++)
          if (tsel[i]) begin
            s_wvalid[i] = m_wvalid[grant];
            s_wdata[i]  = m_wdata[grant];
            s_wstrb[i]  = m_wstrb[grant];
            s_wlast[i]  = (beat_cnt == '0);
          end
      end
      RESP: begin
        m_bvalid[grant] = sel_bvalid;
        m_bid[grant]    = sel_bid[ID_BITS-1:0];
        m_bresp[grant]  = sel_bresp;
        for (int i = 0; i < 2; i++)
          if (tsel[i]) s_bready[i] = m_bready[grant];
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      tsel       <= 2'b00;
      len_q      <= '0;
      beat_cnt   <= '0;
`ifdef AXI_WR_DECERR_EN
      id_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (|m_awvalid) begin
          grant <= arb_grant;
          tsel  <= decode(m_awaddr[arb_grant][ADDR_BITS-1 -: 16]);
          len_q <= m_awlen[arb_grant];
`ifdef AXI_WR_DECERR_EN
          id_q  <= m_awid[arb_grant];
`endif
          state <= ADDR;
        end
        ADDR: if (m_awvalid[grant] && sel_awready) begin
          beat_cnt <= len_q;
          state    <= DATA;
        end
        DATA: if (m_wvalid[grant] && sel_wready) begin
          if (beat_cnt == '0) state <= RESP;
          else beat_cnt <= beat_cnt - 1'b1;
        end
        RESP: if (sel_bvalid && m_bready[grant]) begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {AWREADY_M1, AWREADY_M0} = m_awready;
  assign {WREADY_M1, WREADY_M0}   = m_wready;
  assign {BVALID_M1, BVALID_M0}   = m_bvalid;
  assign {BID_M1, BID_M0}         = m_bid;
  assign {BRESP_M1, BRESP_M0}     = m_bresp;
  assign {AWID_S1, AWID_S0}       = s_awid;
  assign {AWADDR_S1, AWADDR_S0}   = s_awaddr;
  assign {AWLEN_S1, AWLEN_S0}     = s_awlen;
  assign {AWSIZE_S1, AWSIZE_S0}   = s_awsize;
  assign {AWBURST_S1, AWBURST_S0} = s_awburst;
  assign {AWVALID_S1, AWVALID_S0} = s_awvalid;
  assign {WDATA_S1, WDATA_S0}     = s_wdata;
  assign {WSTRB_S1, WSTRB_S0}     = s_wstrb;
  assign {WLAST_S1, WLAST_S0}     = s_wlast;
  assign {WVALID_S1, WVALID_S0}   = s_wvalid;
  assign {BREADY_S1, BREADY_S0}   = s_bready;
endmodule

// File: tb/tb_axi_write_xbar.sv
// Directed bench for axi_write_xbar: two master tasks, two simple slave
// responders, and expected values worked out by hand per scenario.
module tb_axi_write_xbar;
  logic ACLK = 1'b0, ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [1:0][3:0]  m_awid, m_awlen, m_wstrb;
  logic [1:0][31:0] m_awaddr, m_wdata;
  logic [1:0]       m_awvalid, m_wlast, m_wvalid, m_bready;
  logic [2:0] awsize = 3'd2;
  logic [1:0] awburst = 2'b01;

  logic [3:0]  BID_M0, BID_M1;
  logic [1:0]  BRESP_M0, BRESP_M1;
  logic        AWREADY_M0, AWREADY_M1, WREADY_M0, WREADY_M1, BVALID_M0, BVALID_M1;
  logic [7:0]  AWID_S0, AWID_S1;
  logic [31:0] AWADDR_S0, AWADDR_S1, WDATA_S0, WDATA_S1;
  logic [3:0]  AWLEN_S0, AWLEN_S1, WSTRB_S0, WSTRB_S1;
  logic [2:0]  AWSIZE_S0, AWSIZE_S1;
  logic [1:0]  AWBURST_S0, AWBURST_S1;
  logic        AWVALID_S0, AWVALID_S1, WLAST_S0, WLAST_S1, WVALID_S0, WVALID_S1;
  logic        BREADY_S0, BREADY_S1;

  // slave responder state
  logic       wr_tog = 1'b0, tog_q = 1'b0;
  logic [1:0] bpend;
  logic [1:0][7:0] sbid;
  logic [1:0][1:0] bresp_cfg;
  logic [31:0] sdata1;
  wire WREADY_S0 = wr_tog ? tog_q : 1'b1;

  axi_write_xbar dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID_M0(m_awid[0]), .AWID_M1(m_awid[1]), .AWADDR_M0(m_awaddr[0]), .AWADDR_M1(m_awaddr[1]),
    .AWLEN_M0(m_awlen[0]), .AWLEN_M1(m_awlen[1]), .AWSIZE_M0(awsize), .AWSIZE_M1(awsize),
    .AWBURST_M0(awburst), .AWBURST_M1(awburst), .AWVALID_M0(m_awvalid[0]), .AWVALID_M1(m_awvalid[1]),
    .AWREADY_M0(AWREADY_M0), .AWREADY_M1(AWREADY_M1),
    .WDATA_M0(m_wdata[0]), .WDATA_M1(m_wdata[1]), .WSTRB_M0(m_wstrb[0]), .WSTRB_M1(m_wstrb[1]),
    .WLAST_M0(m_wlast[0]), .WLAST_M1(m_wlast[1]), .WVALID_M0(m_wvalid[0]), .WVALID_M1(m_wvalid[1]),
    .WREADY_M0(WREADY_M0), .WREADY_M1(WREADY_M1),
    .BID_M0(BID_M0), .BID_M1(BID_M1), .BRESP_M0(BRESP_M0), .BRESP_M1(BRESP_M1),
    .BVALID_M0(BVALID_M0), .BVALID_M1(BVALID_M1), .BREADY_M0(m_bready[0]), .BREADY_M1(m_bready[1]),
    .AWID_S0(AWID_S0), .AWID_S1(AWID_S1), .AWADDR_S0(AWADDR_S0), .AWADDR_S1(AWADDR_S1),
    .AWLEN_S0(AWLEN_S0), .AWLEN_S1(AWLEN_S1), .AWSIZE_S0(AWSIZE_S0), .AWSIZE_S1(AWSIZE_S1),
    .AWBURST_S0(AWBURST_S0), .AWBURST_S1(AWBURST_S1), .AWVALID_S0(AWVALID_S0), .AWVALID_S1(AWVALID_S1),
    .AWREADY_S0(1'b1), .AWREADY_S1(1'b1),
    .WDATA_S0(WDATA_S0), .WDATA_S1(WDATA_S1), .WSTRB_S0(WSTRB_S0), .WSTRB_S1(WSTRB_S1),
    .WLAST_S0(WLAST_S0), .WLAST_S1(WLAST_S1), .WVALID_S0(WVALID_S0), .WVALID_S1(WVALID_S1),
    .WREADY_S0(WREADY_S0), .WREADY_S1(1'b1),
    .BID_S0(sbid[0]), .BID_S1(sbid[1]), .BRESP_S0(bresp_cfg[0]), .BRESP_S1(bresp_cfg[1]),
    .BVALID_S0(bpend[0]), .BVALID_S1(bpend[1]), .BREADY_S0(BREADY_S0), .BREADY_S1(BREADY_S1)
  );

  wire [1:0] m_awready = {AWREADY_M1, AWREADY_M0};
  wire [1:0] m_wready  = {WREADY_M1, WREADY_M0};
  wire [1:0] m_bvalid  = {BVALID_M1, BVALID_M0};
  wire [1:0][3:0] m_bid   = {BID_M1, BID_M0};
  wire [1:0][1:0] m_bresp = {BRESP_M1, BRESP_M0};
  wire [1:0] s_awv = {AWVALID_S1, AWVALID_S0};
  wire [1:0] s_wv  = {WVALID_S1, WVALID_S0};
  wire [1:0] s_wr  = {1'b1, WREADY_S0};
  wire [1:0] s_wl  = {WLAST_S1, WLAST_S0};
  wire [1:0] s_br  = {BREADY_S1, BREADY_S0};
  wire [1:0][7:0] s_awid = {AWID_S1, AWID_S0};
  wire m0_any = |{AWREADY_M0, WREADY_M0, BVALID_M0, BID_M0, BRESP_M0};
  wire s_any  = |{AWID_S0, AWID_S1, AWADDR_S0, AWADDR_S1, AWLEN_S0, AWLEN_S1, AWSIZE_S0, AWSIZE_S1,
                  AWBURST_S0, AWBURST_S1, AWVALID_S0, AWVALID_S1, WDATA_S0, WDATA_S1, WSTRB_S0,
                  WSTRB_S1, WLAST_S0, WLAST_S1, WVALID_S0, WVALID_S1, BREADY_S0, BREADY_S1};
  wire outs_any = s_any | m0_any | |{AWREADY_M1, WREADY_M1, BVALID_M1, BID_M1, BRESP_M1};

  always @(posedge ACLK) tog_q <= ~tog_q;

  // slave model: capture AWID, raise B after the WLAST beat, drop it on BREADY
  always @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) bpend <= '0;
    else for (int i = 0; i < 2; i++) begin
      if (s_awv[i]) sbid[i] <= s_awid[i];
      if (s_wv[i] && s_wr[i] && s_wl[i]) bpend[i] <= 1'b1;
      if (bpend[i] && s_br[i]) bpend[i] <= 1'b0;
    end

  int aw_cnt[2] = '{0, 0}, w_cnt[2] = '{0, 0}, wlast_cnt[2] = '{0, 0}, wlast_at[2] = '{0, 0};
  int m0_noise = 0, s_noise = 0;
  always @(posedge ACLK)
    for (int i = 0; i < 2; i++) begin
      if (s_awv[i]) aw_cnt[i] <= aw_cnt[i] + 1;
      if (s_wv[i] && s_wr[i]) begin
        w_cnt[i] <= w_cnt[i] + 1;
        if (i == 1) sdata1 <= WDATA_S1;
        if (s_wl[i]) begin
          wlast_cnt[i] <= wlast_cnt[i] + 1;
          wlast_at[i]  <= w_cnt[i] + 1;
        end
      end
    end
  always @(negedge ACLK) begin
    if (m0_any) m0_noise <= m0_noise + 1;
    if (s_any)  s_noise  <= s_noise + 1;
  end

  int n_tests = 0, n_fail = 0;
  int order[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One master write: AW, len+1 W beats, then B (BREADY withheld for bdelay cycles).
  task automatic wr(input int m, input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                    input logic [31:0] d0, input int bdelay, input logic [1:0] exp_resp);
    int n;
    m_awid[m] = id; m_awaddr[m] = addr; m_awlen[m] = len; m_awvalid[m] = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!m_awready[m] && n < 300);
    chk($sformatf("m%0d awready", m), m_awready[m], 1);
    chk($sformatf("m%0d aw latency>=2", m), n >= 2, 1);
    @(posedge ACLK); #1 m_awvalid[m] = 1'b0;
    for (int b = 0; b <= len; b++) begin
      m_wdata[m] = d0 + b; m_wstrb[m] = 4'hF; m_wlast[m] = (b == len); m_wvalid[m] = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end while (!m_wready[m] && n < 50);
      chk($sformatf("m%0d wready", m), m_wready[m], 1);
      @(posedge ACLK); #1;
    end
    m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!m_bvalid[m] && n < 50);
    chk($sformatf("m%0d bvalid", m), m_bvalid[m], 1);
    for (int k = 0; k < bdelay; k++) begin
      chk("b stall bvalid held", m_bvalid[m], 1);
      chk("b stall bready_s", s_br, 0);
      chk("b stall no new grant", {s_awv, m_awready}, 0);
      @(negedge ACLK);
    end
    chk($sformatf("m%0d bid", m), m_bid[m], id);
    chk($sformatf("m%0d bresp", m), m_bresp[m], exp_resp);
    m_bready[m] = 1'b1;
    @(posedge ACLK); #1 m_bready[m] = 1'b0;
    order.push_back(m);
  endtask

  initial begin
    #200000 $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, s2, s3;
    m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0;
    m_wlast = '0; m_wvalid = '0; m_bready = '0; bresp_cfg = '0; sbid = '0;
    #2 chk("reset outputs", outs_any, 0);
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(negedge ACLK) chk("idle outputs", outs_any, 0);
    @(posedge ACLK); #1;

    // 1: single beat M1 -> S1
    s0 = m0_noise; s1 = wlast_cnt[1]; s2 = aw_cnt[1];
    wr(1, 32'h0001_0004, 4'd0, 4'd3, 32'hDEAD_BEEF, 0, 2'b00);
    chk("t1 s1 awid", sbid[1], 8'h23);
    chk("t1 s1 wdata", sdata1, 32'hDEAD_BEEF);
    chk("t1 s1 wlast count", wlast_cnt[1] - s1, 1);
    chk("t1 s1 aw count", aw_cnt[1] - s2, 1);
    chk("t1 m0 quiet", m0_noise - s0, 0);

    // 2: simultaneous requests, round robin
    order.delete();
    fork
      wr(0, 32'h0000_0010, 4'd0, 4'd1, 32'h11, 0, 2'b00);
      wr(1, 32'h0001_0010, 4'd0, 4'd2, 32'h22, 0, 2'b00);
    join
    fork
      wr(0, 32'h0000_0020, 4'd0, 4'd4, 32'h33, 0, 2'b00);
      wr(1, 32'h0001_0020, 4'd0, 4'd5, 32'h44, 0, 2'b00);
    join
    chk("t2 first", order[0], 0);
    chk("t2 second", order[1], 1);
    chk("t2 third pair first", order[2], 0);

    // 3: 4-beat burst into a throttled S0
    s0 = w_cnt[0]; s1 = wlast_cnt[0];
    wr_tog = 1'b1;
    wr(0, 32'h0000_0100, 4'd3, 4'd6, 32'hA0, 0, 2'b00);
    wr_tog = 1'b0;
    chk("t3 beats", w_cnt[0] - s0, 4);
    chk("t3 wlast count", wlast_cnt[0] - s1, 1);
    chk("t3 wlast on beat 4", wlast_at[0] - s0, 4);

    // 4: unmapped address
    s0 = aw_cnt[0]; s1 = aw_cnt[1]; s2 = s_noise;
    bresp_cfg[1] = 2'b10;
`ifdef AXI_WR_DECERR_EN
    wr(1, 32'h0002_0000, 4'd0, 4'd9, 32'h55, 0, 2'b11);
    chk("t4 s0 idle", aw_cnt[0] - s0, 0);
    chk("t4 s1 idle", aw_cnt[1] - s1, 0);
    chk("t4 slave ports quiet", s_noise - s2, 0);
`else
    wr(1, 32'h0002_0000, 4'd0, 4'd9, 32'h55, 0, 2'b10);
    chk("t4 s0 idle", aw_cnt[0] - s0, 0);
    chk("t4 s1 catch-all", aw_cnt[1] - s1, 1);
    chk("t4 s1 awid", sbid[1], 8'h29);
`endif
    bresp_cfg[1] = 2'b00;

    // 5: B back-pressure with M0 waiting
    order.delete();
    fork
      wr(1, 32'h0001_0008, 4'd0, 4'd7, 32'h66, 5, 2'b00);
      begin
        repeat (2) @(posedge ACLK);
        #1 wr(0, 32'h0000_0030, 4'd0, 4'd2, 32'h77, 0, 2'b00);
      end
    join
    chk("t5 m1 first", order[0], 1);
    chk("t5 m0 after", order[1], 0);

    // 6: reset in the middle of a 4-beat burst
    s3 = w_cnt[0];
    m_awid[0] = 4'd8; m_awaddr[0] = 32'h0000_0040; m_awlen[0] = 4'd3; m_awvalid[0] = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("t6 awready", AWREADY_M0, 1);
    @(posedge ACLK); #1 m_awvalid[0] = 1'b0;
    m_wdata[0] = 32'hB0; m_wstrb[0] = 4'hF; m_wvalid[0] = 1'b1;
    @(negedge ACLK) chk("t6 wready", WREADY_M0, 1);
    @(posedge ACLK); #1 m_wdata[0] = 32'hB1;
    @(negedge ACLK) chk("t6 beat2 wvalid_s0", WVALID_S0, 1);
    @(posedge ACLK); #1 ARESETn = 1'b0;
    #1 chk("t6 outputs on reset", outs_any, 0);
    chk("t6 beats before reset", w_cnt[0] - s3, 2);
    m_wvalid[0] = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK) ARESETn = 1'b1;
    @(posedge ACLK); #1;
    wr(0, 32'h0000_0050, 4'd0, 4'd5, 32'hC0, 0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
